// File: rtl/mem_access_unit.sv
// mem_access_unit: fixed-latency word memory with valid/ready port, feeding IR (fetch) and MDR (load).
module mem_access_unit #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_is_inst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misaligned,
  output logic [31:0] ir_out,
  output logic [6:0]  opcode_out,
  output logic [31:0] mdr_out,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH) + 2;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d;
  logic write_q, write_d, inst_q, inst_d;
  logic [31:0] mem [DEPTH];
  logic done, mis, unused_addr;
  assign unused_addr = ^req_addr[31:AW];
  assign done = state_q == DONE;
  assign mis = addr_q[1:0] != 2'b00;
  assign resp_rdata = (done && !write_q && !mis) ? mem[addr_q[AW-1:2]] : '0;
  assign req_ready = state_q == IDLE;
  assign busy = !req_ready;
  assign resp_valid = done;
  assign misaligned = done && mis;
  assign ir_out = ir_q;
  assign opcode_out = ir_q[6:0];
  assign mdr_out = mdr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    inst_d = inst_q;
    ir_d = ir_q;
    mdr_d = mdr_q;
    if (state_q == IDLE && req_valid) begin
      state_d = (LATENCY == 1) ? DONE : WAIT;
      cnt_d = 4'(LATENCY - 1);
      addr_d = req_addr[AW-1:0];
      wdata_d = req_wdata;
      write_d = req_write;
      inst_d = req_is_inst;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? DONE : WAIT;
    end else if (done) begin
      state_d = IDLE;
      ir_d = (!write_q && inst_q) ? resp_rdata : ir_q;
      mdr_d = (!write_q && !inst_q) ? resp_rdata : mdr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      inst_q <= 1'b0;
      ir_q <= '0;
      mdr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      inst_q <= inst_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
    end
  end
  // Reset in the same cycle as DONE discards the pending store.
  always_ff @(posedge clk) begin
    if (!reset && done && write_q && !mis) mem[addr_q[AW-1:2]] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed tests of mem_access_unit at LATENCY=4 (dut0) and LATENCY=1 (dut1).
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_is_inst = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rdy0, rv0, mis0, busy0, rdy1, rv1, mis1, busy1;
  logic [31:0] rd0, ir0, mdr0, rd1, ir1, mdr1;
  logic [6:0] op0, op1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  mem_access_unit #(.LATENCY(4), .DEPTH(16384)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0), .req_write(req_write),
    .req_is_inst(req_is_inst), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_rdata(rd0), .misaligned(mis0), .ir_out(ir0), .opcode_out(op0), .mdr_out(mdr0), .busy(busy0));
  mem_access_unit #(.LATENCY(1), .DEPTH(16384)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_write(req_write),
    .req_is_inst(req_is_inst), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .misaligned(mis1), .ir_out(ir1), .opcode_out(op1), .mdr_out(mdr1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, returns latency, busy cycles, response data and misaligned flag.
  task automatic do_req(input bit sel, input bit wr, input bit inst, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int busy_n, output logic [31:0] rd, output logic mis);
    lat = -1;
    busy_n = 0;
    rd = 'x;
    mis = 1'bx;
    req_valid = 1'b1;
    req_write = wr;
    req_is_inst = inst;
    req_addr = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (!(sel ? rdy1 : rdy0)) busy_n++;
      if ((sel ? rv1 : rv0) && lat < 0) begin
        lat = n;
        rd = sel ? rd1 : rd0;
        mis = sel ? mis1 : mis0;
      end
      if (sel ? rdy1 : rdy0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", rv0); end
    checks++; if (mis0 !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", mis0); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rd0); end
    checks++; if (ir0 !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir0); end
    checks++; if (mdr0 !== 32'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=0", mdr0); end
  endtask

  task automatic preload();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    do_req(0, 1, 0, 32'h0, 32'h00500093, lat, bn, rd, m);
    do_req(0, 1, 0, 32'h8, 32'hAAAA0002, lat, bn, rd, m);
  endtask

  task automatic test_fetch();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    do_req(0, 0, 1, 32'h0, 32'h0, lat, bn, rd, m);
    checks++; if (lat !== 4) begin failures++; $display("FAIL fetch_latency got=%0d exp=4", lat); end
    checks++; if (rd !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", rd); end
    checks++; if (ir0 !== 32'h00500093) begin failures++; $display("FAIL fetch_ir got=%h exp=00500093", ir0); end
    checks++; if (op0 !== 7'h13) begin failures++; $display("FAIL fetch_opcode got=%h exp=13", op0); end
    checks++; if (mdr0 !== 32'h0) begin failures++; $display("FAIL fetch_mdr got=%h exp=0", mdr0); end
  endtask

  task automatic test_store_load();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    do_req(0, 1, 0, 32'h40, 32'hDEADBEEF, lat, bn, rd, m);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", rd); end
    checks++; if (bn + 1 !== 5) begin failures++; $display("FAIL store_occupancy got=%0d exp=5", bn + 1); end
    do_req(0, 0, 0, 32'h40, 32'h0, lat, bn, rd, m);
    checks++; if (bn + 1 !== 5) begin failures++; $display("FAIL load_occupancy got=%0d exp=5", bn + 1); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
    checks++; if (mdr0 !== 32'hDEADBEEF) begin failures++; $display("FAIL load_mdr got=%h exp=deadbeef", mdr0); end
    checks++; if (ir0 !== 32'h00500093) begin failures++; $display("FAIL load_ir_held got=%h exp=00500093", ir0); end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int np = 0, extra = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_is_inst = 1'b0;
    req_addr = 32'h8;
    for (int c = 1; c <= 30 && np < 3; c++) begin
      tick();
      if (rv0) begin
        t[np] = c;
        np++;
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rv0) extra++;
    end
    checks++; if (np !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", np); end
    if (np == 3) begin
      checks++; if (t[1] - t[0] !== 5) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=5", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 5) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=5", t[2] - t[1]); end
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=0", extra); end
    checks++; if (mdr0 !== 32'hAAAA0002) begin failures++; $display("FAIL b2b_mdr got=%h exp=aaaa0002", mdr0); end
  endtask

  task automatic test_misaligned();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    do_req(0, 0, 0, 32'h42, 32'h0, lat, bn, rd, m);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mis_load_latency got=%0d exp=4", lat); end
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL mis_load_flag got=%b exp=1", m); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_load_rdata got=%h exp=0", rd); end
    checks++; if (mdr0 !== 32'h0) begin failures++; $display("FAIL mis_load_mdr got=%h exp=0", mdr0); end
    do_req(0, 1, 0, 32'h43, 32'h55555555, lat, bn, rd, m);
    checks++; if (m !== 1'b1) begin failures++; $display("FAIL mis_store_flag got=%b exp=1", m); end
    do_req(0, 0, 0, 32'h40, 32'h0, lat, bn, rd, m);
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL aligned_flag got=%b exp=0", m); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_store_kept got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_reset_abort();
    int lat, bn, pulses = 0;
    logic [31:0] rd;
    logic m;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 32'h40;
    req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    if (rv0) pulses++;
    tick();
    if (rv0) pulses++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", rdy0); end
    for (int c = 0; c < 6; c++) begin
      if (rv0) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_resp got=%0d exp=0", pulses); end
    do_req(0, 0, 0, 32'h40, 32'h0, lat, bn, rd, m);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL abort_old_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_wrap();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    do_req(0, 0, 0, 32'h10008, 32'h0, lat, bn, rd, m);
    checks++; if (rd !== 32'hAAAA0002) begin failures++; $display("FAIL wrap_rdata got=%h exp=aaaa0002", rd); end
    checks++; if (m !== 1'b0) begin failures++; $display("FAIL wrap_flag got=%b exp=0", m); end
  endtask

  task automatic test_latency1();
    int lat, bn;
    logic [31:0] rd;
    logic m;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_req(1, 0, 1, 32'h0, 32'h0, lat, bn, rd, m);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lat1_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h00500093) begin failures++; $display("FAIL lat1_rdata got=%h exp=00500093", rd); end
    checks++; if (ir1 !== 32'h00500093) begin failures++; $display("FAIL lat1_ir got=%h exp=00500093", ir1); end
    checks++; if (op1 !== 7'h13) begin failures++; $display("FAIL lat1_opcode got=%h exp=13", op1); end
  endtask

  initial begin
    test_reset();
    preload();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_reset_abort();
    test_wrap();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
